nv_ram_rws_pclr: RTL and testbench

Parametrised one-read/one-write synchronous RAM with per-lane write masking, read-during-write bypass, an optional output pipeline register and a hardware clear engine. After every reset, and on request, the clear engine sweeps the whole array to zero. It replaces the fixed-geometry 32-entry RAMs used by the accumulator buffers and serves any CACC/CDMA datapath needing a zero-initialised scratch store.

---
 rtl/nv_ram_pkg.sv | 37 +++
 rtl/nv_ram_clr_fsm.sv | 62 ++++++
 rtl/nv_ram_rws_pclr.sv | 121 ++++++++++++
 tb/tb_nv_ram_rws_pclr.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the nv_ram family: clear-engine state encoding,
// lane-mask expansion and geometry legality checking.
package nv_ram_pkg;

    localparam int unsigned NV_MAX_WIDTH = 4096;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } nv_ram_state_e;

    // Bit b of the result follows mask bit b/lane; bits at or above width are zero.
    function automatic logic [NV_MAX_WIDTH-1:0] nv_mask_expand(
        input logic [NV_MAX_WIDTH-1:0] mask,
        input int unsigned             width,
        input int unsigned             lane
    );
        logic [NV_MAX_WIDTH-1:0] bits;
        bits = '0;
        for (int unsigned b = 0; b < NV_MAX_WIDTH; b++) begin
            if (b < width) begin
                bits[b] = mask[b / lane];
            end
        end
        return bits;
    endfunction

    function automatic bit nv_geom_ok(
        input int unsigned width,
        input int unsigned depth,
        input int unsigned lane
    );
        return (lane != 0) && (width != 0) && (width <= NV_MAX_WIDTH) &&
               ((width % lane) == 0) && (depth >= 2);
    endfunction

endpackage

// File: rtl/nv_ram_clr_fsm.sv
// Clear engine: sweeps every entry to zero after reset or on a clr pulse,
// then reports the array usable through init_done.
module nv_ram_clr_fsm
    import nv_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    output logic          init_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_wa
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    nv_ram_state_e state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (ptr == LAST) begin
                    state_nxt = READY;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + AW'(1);
                end
            end
            READY: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign init_done = (state == READY);
    assign clr_wa    = ptr;

endmodule

// File: rtl/nv_ram_rws_pclr.sv
// One-read/one-write RAM with lane write masks, read-during-write bypass,
// optional output register and a zeroing clear engine.
module nv_ram_rws_pclr
    import nv_ram_pkg::*;
#(
    parameter  int unsigned WIDTH   = 512,
    parameter  int unsigned DEPTH   = 32,
    parameter  int unsigned LANE    = 8,
    parameter  int unsigned OUT_REG = 0,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic [AW-1:0]         ra,
    input  logic                  re,
    output logic [WIDTH-1:0]      dout,
    output logic                  rd_vld,
    input  logic [AW-1:0]         wa,
    input  logic                  we,
    input  logic [WIDTH/LANE-1:0] wmask,
    input  logic [WIDTH-1:0]      di,
    output logic                  init_done,
    input  logic [31:0]           pwrbus_ram_pd
);

    if (!nv_geom_ok(WIDTH, DEPTH, LANE)) begin : g_bad_geom
        $error("nv_ram_rws_pclr: illegal geometry WIDTH=%0d DEPTH=%0d LANE=%0d",
               WIDTH, DEPTH, LANE);
    end

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic             unused_pwrbus;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_wa;
    logic             wa_ok, ra_ok, user_we, rd_fire;
    logic [WIDTH-1:0] bm, wr_old, merged_w, rd_word;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] data1;
    logic             vld1;

    assign unused_pwrbus = ^pwrbus_ram_pd;

    nv_ram_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .init_done (init_done),
        .clr_we    (clr_we),
        .clr_wa    (clr_wa)
    );

    assign wa_ok    = ({1'b0, wa} < DEPTH_W);
    assign ra_ok    = ({1'b0, ra} < DEPTH_W);
    assign user_we  = init_done & we & wa_ok;
    assign rd_fire  = init_done & re;
    assign bm       = WIDTH'(nv_mask_expand(NV_MAX_WIDTH'(wmask), WIDTH, LANE));
    assign wr_old   = wa_ok ? mem[wa] : '0;
    assign merged_w = (wr_old & ~bm) | (di & bm);

    // Clear writes only happen outside READY, so they never collide with user writes.
    assign wr_en   = clr_we | user_we;
    assign wr_addr = clr_we ? clr_wa : wa;
    assign wr_word = clr_we ? '0 : merged_w;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_comb begin
        rd_word = '0;
        if (ra_ok) begin
            rd_word = (user_we && (wa == ra)) ? merged_w : mem[ra];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data1 <= '0;
            vld1  <= 1'b0;
        end else begin
            vld1 <= rd_fire;
            if (rd_fire) begin
                data1 <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] data2;
        logic             vld2;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                data2 <= '0;
                vld2  <= 1'b0;
            end else begin
                vld2 <= vld1;
                if (vld1) begin
                    data2 <= data1;
                end
            end
        end

        assign dout   = data2;
        assign rd_vld = vld2;
    end else begin : g_no_out_reg
        assign dout   = data1;
        assign rd_vld = vld1;
    end

endmodule

// File: tb/tb_nv_ram_rws_pclr.sv
// Bench for nv_ram_rws_pclr: two instances (OUT_REG=0/1) share stimulus and are
// checked every cycle against an array-level reference model plus directed vectors.
module tb_nv_ram_rws_pclr;

    localparam int unsigned W = 32;
    localparam int unsigned D = 20;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  ra = '0;
    logic [4:0]  wa = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] di = '0;
    logic [31:0] dout0, dout1;
    logic        vld0, vld1, init0, init1;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] mm [D];
    int          clr_left;
    logic [31:0] exp_d0, exp_d1;
    logic        exp_v0, exp_v1;

    always #5 clk = ~clk;

    nv_ram_rws_pclr #(.WIDTH(W), .DEPTH(D), .LANE(8), .OUT_REG(0)) dut0 (
        .clk(clk), .rstn(rstn), .clr(clr), .ra(ra), .re(re), .dout(dout0),
        .rd_vld(vld0), .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_done(init0), .pwrbus_ram_pd(32'h0)
    );

    nv_ram_rws_pclr #(.WIDTH(W), .DEPTH(D), .LANE(8), .OUT_REG(1)) dut1 (
        .clk(clk), .rstn(rstn), .clr(clr), .ra(ra), .re(re), .dout(dout1),
        .rd_vld(vld1), .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_done(init1), .pwrbus_ram_pd(32'h0)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        clr_left = D;
        exp_d0 = '0; exp_v0 = 1'b0;
        exp_d1 = '0; exp_v1 = 1'b0;
    endtask

    // One clock edge of behaviour, evaluated on the inputs present at that edge.
    task automatic model_edge();
        if (exp_v0) exp_d1 = exp_d0;
        exp_v1 = exp_v0;
        if (clr_left > 0) begin
            mm[D - clr_left] = '0;
            clr_left--;
            exp_v0 = 1'b0;
        end else begin
            if (we && wa < D) begin
                for (int l = 0; l < 4; l++) begin
                    if (wmask[l]) mm[wa][l*8 +: 8] = di[l*8 +: 8];
                end
            end
            if (re) begin
                exp_d0 = (ra < D) ? mm[ra] : 32'h0;
                exp_v0 = 1'b1;
            end else begin
                exp_v0 = 1'b0;
            end
            if (clr) clr_left = D;
        end
    endtask

    task automatic check_all();
        chk("dout_r0", dout0, exp_d0);
        chk("rd_vld_r0", {31'b0, vld0}, {31'b0, exp_v0});
        chk("dout_r1", dout1, exp_d1);
        chk("rd_vld_r1", {31'b0, vld1}, {31'b0, exp_v1});
        chk("init_done_r0", {31'b0, init0}, {31'b0, clr_left == 0});
        chk("init_done_r1", {31'b0, init1}, {31'b0, clr_left == 0});
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rstn) model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        clr = 1'b0; re = 1'b0; we = 1'b0;
        ra = '0; wa = '0; wmask = '0; di = '0;
    endtask

    task automatic do_reset(input int hold);
        idle();
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (hold) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init0 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    task automatic write_word(input int a, input logic [31:0] v);
        we = 1'b1; wa = 5'(a); wmask = 4'hF; di = v;
        cyc();
        we = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [3:0]  wm;
        logic [31:0] di;
        logic        re;
        logic [4:0]  ra;
        logic [31:0] exp_d;
        logic        exp_v;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n;
        tbl[0]  = '{1'b1, 5'd5,  4'hF, 32'hAABBCCDD, 1'b0, 5'd0,  32'h00000000, 1'b0};
        tbl[1]  = '{1'b1, 5'd5,  4'h5, 32'h11223344, 1'b0, 5'd0,  32'h00000000, 1'b0};
        tbl[2]  = '{1'b0, 5'd0,  4'h0, 32'h00000000, 1'b1, 5'd5,  32'hAA22CC44, 1'b1};
        tbl[3]  = '{1'b1, 5'd7,  4'h3, 32'hDEADBEEF, 1'b1, 5'd7,  32'h0000BEEF, 1'b1};
        tbl[4]  = '{1'b1, 5'd25, 4'hF, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0000BEEF, 1'b0};
        tbl[5]  = '{1'b0, 5'd0,  4'h0, 32'h00000000, 1'b1, 5'd25, 32'h00000000, 1'b1};
        tbl[6]  = '{1'b0, 5'd0,  4'h0, 32'h00000000, 1'b1, 5'd7,  32'h0000BEEF, 1'b1};
        tbl[7]  = '{1'b0, 5'd0,  4'h0, 32'h00000000, 1'b1, 5'd19, 32'h00000000, 1'b1};
        tbl[8]  = '{1'b1, 5'd19, 4'hF, 32'h12345678, 1'b1, 5'd0,  32'h00000000, 1'b1};
        tbl[9]  = '{1'b0, 5'd0,  4'h0, 32'h00000000, 1'b1, 5'd19, 32'h12345678, 1'b1};
        tbl[10] = '{1'b1, 5'd31, 4'hF, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h12345678, 1'b0};

        // power-up: clear must take exactly D edges even with re/we held high
        do_reset(3);
        re = 1'b1; we = 1'b1; wa = 5'd3; wmask = 4'hF; di = 32'hFFFFFFFF;
        wait_init(n);
        chk("init_after_reset_edges", 32'(n), 32'(D));
        idle();

        for (int a = 0; a < int'(D); a++) begin
            re = 1'b1; ra = 5'(a);
            cyc();
        end
        idle();
        cyc();

        for (int i = 0; i < 11; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wmask = tbl[i].wm; di = tbl[i].di;
            re = tbl[i].re; ra = tbl[i].ra;
            cyc();
            chk("tbl_dout", dout0, tbl[i].exp_d);
            chk("tbl_rd_vld", {31'b0, vld0}, {31'b0, tbl[i].exp_v});
        end
        idle();

        // no valid entry may have been touched by the out-of-range writes
        for (int a = 0; a < int'(D); a++) begin
            re = 1'b1; ra = 5'(a);
            cyc();
        end
        idle();

        // consecutive reads through the registered output stay in order
        for (int a = 0; a < 4; a++) write_word(a, 32'hC0DE0000 + 32'(a));
        for (int i = 0; i < 6; i++) begin
            re = (i < 4); ra = 5'(i);
            cyc();
            if (i >= 1 && i <= 4) chk("outreg_order", dout1, 32'hC0DE0000 + 32'(i - 1));
        end
        chk("outreg_hold", dout1, 32'hC0DE0003);
        idle();

        // fill, clear on request with reads attempted throughout, then read back
        for (int a = 0; a < int'(D); a++) write_word(a, 32'h5A000000 | 32'(a + 1));
        clr = 1'b1; re = 1'b1; ra = 5'd2;
        cyc();
        clr = 1'b0;
        chk("init_low_after_clr", {31'b0, init0}, 32'h0);
        wait_init(n);
        chk("init_after_clr_edges", 32'(n), 32'(D));
        idle();
        for (int a = 0; a < int'(D); a++) begin
            re = 1'b1; ra = 5'(a);
            cyc();
        end
        idle();
        cyc();

        // randomized traffic with occasional clear requests
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            wmask = 4'($urandom);
            di = $urandom;
            clr = ($urandom_range(0, 59) == 0);
            cyc();
        end
        idle();
        wait_init(n);
        chk("init_after_random", {31'b0, init0}, 32'h1);

        // reset asserted with the clear pointer at 10 restarts the sweep
        do_reset(2);
        repeat (10) cyc();
        chk("mid_clear_busy", {31'b0, init0}, 32'h0);
        do_reset(2);
        wait_init(n);
        chk("init_after_midclear_reset", 32'(n), 32'(D));
        for (int a = 0; a < int'(D); a++) begin
            re = 1'b1; ra = 5'(a);
            cyc();
        end
        idle();
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
